// File: rtl/vram_writer.sv
// Write-side controller for the 128x96 VRAM: fills the visible region in raster
// order from a constant clear colour or a valid/ready pixel stream.
module vram_writer #(
    parameter int unsigned PIXEL_W = 3,
    parameter int unsigned ROWS    = 96,
    parameter int unsigned COLS    = 128,
    localparam int unsigned ROW_W  = 7,
    localparam int unsigned COL_W  = 7,
    localparam int unsigned ADDR_W = ROW_W + COL_W,
    parameter logic [ADDR_W-1:0] BLANK_ADDR = 14'd9462
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_clear,
    input  logic [PIXEL_W-1:0] clear_color,
    input  logic               start_frame,
    input  logic [PIXEL_W-1:0] pix_data,
    input  logic               pix_valid,
    output logic               pix_ready,
    output logic               we,
    output logic [ADDR_W-1:0]  waddr,
    output logic [PIXEL_W-1:0] wdata,
    output logic               busy,
    output logic               frame_done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLEAR  = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [ROW_W-1:0]   r_row;
    logic [COL_W-1:0]   r_col;
    logic [PIXEL_W-1:0] r_color;

    logic               r_we;
    logic [ADDR_W-1:0]  r_waddr;
    logic [PIXEL_W-1:0] r_wdata;
    logic               r_pix_ready;
    logic               r_busy;
    logic               r_frame_done;

    logic               w_last;
    logic               w_col_last;
    logic [ADDR_W-1:0]  w_cur_addr;
    logic               w_wr;
    logic               w_latch_color;
    logic [PIXEL_W-1:0] w_src_data;
    logic [PIXEL_W-1:0] w_wdata_nxt;

    assign w_col_last = (r_col == COL_W'(COLS - 1));
    assign w_last     = (r_row == ROW_W'(ROWS - 1)) && w_col_last;
    assign w_cur_addr = {r_row, r_col};

    // The blanking pixel must always read back as black.
    assign w_wdata_nxt = (w_cur_addr == BLANK_ADDR) ? '0 : w_src_data;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_clear) begin
                    w_state_nxt = S_CLEAR;
                end else if (start_frame) begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_CLEAR: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_STREAM: begin
                if (pix_valid && r_pix_ready && w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Write-request decode; the first clear write issues on the start edge itself.
    always_comb begin
        w_wr          = 1'b0;
        w_latch_color = 1'b0;
        w_src_data    = r_color;
        case (r_state)
            S_IDLE: begin
                if (start_clear) begin
                    w_wr          = 1'b1;
                    w_latch_color = 1'b1;
                    w_src_data    = clear_color;
                end
            end
            S_CLEAR: begin
                w_wr = 1'b1;
            end
            S_STREAM: begin
                w_wr       = pix_valid && r_pix_ready;
                w_src_data = pix_data;
            end
            default: begin
                w_wr = 1'b0;
            end
        endcase
    end

    // Registered outputs and raster counters; counters sit at 0 whenever idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row        <= '0;
            r_col        <= '0;
            r_color      <= '0;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_pix_ready  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_we         <= w_wr;
            r_frame_done <= w_wr && w_last;
            r_busy       <= (w_state_nxt != S_IDLE);
            r_pix_ready  <= (w_state_nxt == S_STREAM);
            if (w_latch_color) begin
                r_color <= clear_color;
            end
            if (w_wr) begin
                r_waddr <= w_cur_addr;
                r_wdata <= w_wdata_nxt;
                if (w_last) begin
                    r_row <= '0;
                    r_col <= '0;
                end else if (w_col_last) begin
                    r_col <= '0;
                    r_row <= r_row + ROW_W'(1);
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end
        end
    end

    assign we         = r_we;
    assign waddr      = r_waddr;
    assign wdata      = r_wdata;
    assign pix_ready  = r_pix_ready;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

// File: doc/vram_writer.md
# vram_writer

Write-side controller for the 128x96 pixel VRAM whose read side is addressed by the VGA display path with `{row[6:0], col[6:0]}`. It fills the visible region in raster order, either with a constant clear colour or from a valid/ready pixel stream. It forces the reserved blanking-pixel address to black on every write. It drives the VRAM write port directly and reports completion with a one-cycle pulse.

## Interface
- `PIXEL_W`, 3: pixel width in bits (RGB).
- `ROWS`, 96: visible rows, written 0..ROWS-1.
- `COLS`, 128: visible columns, written 0..COLS-1 (fills 7 bits).
- `BLANK_ADDR`, 14'd9462 (row 73, col 118): address the display path reads during blanking; it must always hold 0.

- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start_clear`  in  1  request a fill with `clear_color`; sampled only in IDLE.
- `clear_color`  in  PIXEL_W  fill colour; sampled with `start_clear` and held internally.
- `start_frame`  in  1  request a streamed frame; sampled only in IDLE.
- `pix_data`  in  PIXEL_W  stream pixel.
- `pix_valid`  in  1  `pix_data` valid.
- `pix_ready`  out  1  block accepts a pixel this cycle.
- `we`  out  1  VRAM write enable.
- `waddr`  out  14  VRAM write address `{row[6:0], col[6:0]}`.
- `wdata`  out  PIXEL_W  VRAM write data.
- `busy`  out  1  high in any state other than IDLE.
- `frame_done`  out  1  one-cycle pulse coincident with the final write.

## Operation
- FSM states are IDLE, CLEAR, STREAM and DONE.
- Reset values:
  - state = IDLE; row and col = 0.
  - `we`, `pix_ready`, `busy` and `frame_done` = 0.
  - `waddr` = 0, `wdata` = 0.
- IDLE:
  - `start_clear` → CLEAR, latching `clear_color`.
  - Otherwise `start_frame` → STREAM.
  - If both are high in the same cycle, `start_clear` wins and `start_frame` is dropped.
  - Starts are ignored in every state other than IDLE (no queuing).
- CLEAR:
  - One write per cycle, raster order: col 0..COLS-1 within a row, then row+1.
  - `wdata` = latched colour.
  - After the write to `{ROWS-1, COLS-1}` the block goes to DONE.
- STREAM:
  - `pix_ready` = 1 until the last pixel has been accepted.
  - A beat transfers when `pix_valid && pix_ready`.
  - Each accepted beat produces exactly one write at the current {row,col}, then the counters advance.
  - Cycles without a transfer produce `we` = 0 and the counters hold.
  - After the beat for `{ROWS-1, COLS-1}` is accepted, `pix_ready` drops.
- DONE: lasts one cycle (the final write's cycle, `frame_done` = 1), then IDLE.
- Counter wrap: col wraps COLS-1→0 and increments row; row never exceeds ROWS-1.
- Blanking protection: any write with `waddr == BLANK_ADDR` has `wdata` forced to 0, in both CLEAR and STREAM. In STREAM the beat is still consumed.
- `waddr` and `wdata` are don't-care when `we` = 0, but they are registered and hold their last value.
- Reset mid-operation:
  - Immediate return to IDLE and all reset values, regardless of state.
  - VRAM contents already written are left as they are.
  - There is no resume.

## Timing
- All outputs are registered.
- CLEAR latency (`start_clear` sampled at edge N):
  - First write (`waddr` 0) is on the ports in the cycle after edge N.
  - Writes are continuous, one per cycle.
  - The last write (`waddr` 12287 = `{95,127}`) appears in cycle N+12288, with `frame_done` = 1.
  - `busy` = 0 from cycle N+12289.
- STREAM latency:
  - A beat accepted at edge k appears as `we`/`waddr`/`wdata` in the cycle following edge k.
  - `pix_ready` rises the cycle after `start_frame` is sampled.
  - Back-to-back beats sustain one write per cycle.
- `frame_done` is high for exactly one cycle per completed operation. It is never asserted for an operation cut short by reset.
- `busy` rises the cycle after an accepted start. It falls the cycle after `frame_done`.

## Test plan
- Reset: assert `reset` asynchronously between edges → all outputs 0 immediately. Then deassert; with no starts there are no writes for 100 cycles.
- Clear with `clear_color` = 3'b101:
  - Exactly 12288 consecutive writes, `waddr` 0..12287 in order.
  - `wdata` = 3'b101 everywhere except `waddr` 9462, which gets 3'b000.
  - `frame_done` is a single pulse on `waddr` 12287; `busy` is low the next cycle.
- Stream with `pix_valid` toggling 1,0,1,1,0 and `pix_data` = col[2:0]:
  - Writes occur only on the cycle after each accepted beat.
  - Addresses are contiguous with no skips.
  - Total 12288 writes, and the 9462 write carries 0.
  - `pix_ready` falls after beat 12288; `frame_done` is high on the final write.
- Simultaneous `start_clear` and `start_frame` in IDLE → CLEAR only; `pix_ready` stays 0 throughout.
- `start_frame` pulsed while `busy` (mid-CLEAR) → ignored; after `frame_done`, the block idles with no stream.
- Reset asserted after 500 streamed beats → IDLE immediately, no `frame_done`. A new `start_frame` then restarts at `waddr` 0.
